// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern engine.
//   MODE_*  : run-time pattern selection values carried on the mode input
//   state_e : pattern sequencer states
package led_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_DRAIN  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..TICK_CNT-1 and wraps, pulsing tick in the last count.
//   sys_clk : clock
//   sys_rst : synchronous active-high reset (count to 0)
//   clr     : synchronous clear (count to 0), wins over en
//   en      : count enable; when low the count is held and tick is suppressed
//   tick    : combinational, high while count == TICK_CNT-1 and en is high
module led_tick_gen #(
  parameter int unsigned TICK_CNT = 10_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_CNT);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CNT - 1);

  logic [CntW-1:0] count_q, count_d;
  logic            at_max;

  assign at_max = (count_q == CntMax);
  assign tick   = en && at_max;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = at_max ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaled step tick advances one of four patterns
// (rotate left, rotate right, drain, bounce) with run-time mode load, restart
// and pause.
//   sys_clk   : clock
//   sys_rst   : synchronous active-high reset
//   mode      : requested mode (0 ROT_L, 1 ROT_R, 2 DRAIN, 3 BOUNCE)
//   mode_load : strobe, latch mode and reseed the pattern
//   restart   : strobe, reseed the current mode
//   pause     : level, freezes prescaler and pattern
//   led       : LED drive, 1 = on (registered)
//   cur_mode  : mode currently executing (registered)
//   tick      : combinational step pulse; the closing edge of that cycle steps
//   done      : DRAIN finished and holding all LEDs off (registered)
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned NUM_LED   = 4,
  parameter int unsigned TICK_CNT  = 10_000_000,
  parameter logic [1:0]  INIT_MODE = 2'd0
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode,
  input  logic               mode_load,
  input  logic               restart,
  input  logic               pause,
  output logic [NUM_LED-1:0] led,
  output logic [1:0]         cur_mode,
  output logic               tick,
  output logic               done
);

  localparam logic [NUM_LED-1:0] LedLsb = NUM_LED'(1);
  localparam logic [NUM_LED-1:0] LedMsb = LedLsb << (NUM_LED - 1);
  localparam logic [NUM_LED-1:0] LedAll = '1;

  state_e             state_q;
  logic [NUM_LED-1:0] led_q;
  logic [1:0]         cur_mode_q;
  logic               dir_up_q;
  logic               done_q;
  logic               tick_en;
  logic               tick_clr;

  function automatic logic [NUM_LED-1:0] seed(input logic [1:0] m);
    logic [NUM_LED-1:0] s;
    case (m)
      MODE_ROT_R: s = LedMsb;
      MODE_DRAIN: s = LedAll;
      default:    s = LedLsb;  // ROT_L and BOUNCE both start at bit0
    endcase
    return s;
  endfunction

  // Prescaler runs only while a pattern is live; in HOLD it stays parked at 0.
  assign tick_en  = !pause && (state_q != StHold);
  assign tick_clr = mode_load || restart;

  led_tick_gen #(
    .TICK_CNT (TICK_CNT)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (tick_clr),
    .en      (tick_en),
    .tick    (tick)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      led_q      <= '0;
      cur_mode_q <= INIT_MODE;
      dir_up_q   <= 1'b1;
      done_q     <= 1'b0;
    end else if (mode_load) begin
      state_q    <= StRun;
      led_q      <= seed(mode);
      cur_mode_q <= mode;
      dir_up_q   <= 1'b1;
      done_q     <= 1'b0;
    end else if (restart) begin
      state_q  <= StRun;
      led_q    <= seed(cur_mode_q);
      dir_up_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (tick) begin
      // tick already implies !pause and state != HOLD
      case (state_q)
        StIdle: begin
          led_q    <= seed(cur_mode_q);
          dir_up_q <= 1'b1;
          state_q  <= StRun;
        end
        StRun: begin
          case (cur_mode_q)
            MODE_ROT_L: led_q <= {led_q[NUM_LED-2:0], led_q[NUM_LED-1]};
            MODE_ROT_R: led_q <= {led_q[0], led_q[NUM_LED-1:1]};
            MODE_DRAIN: begin
              led_q <= led_q >> 1;
              if ((led_q >> 1) == '0) begin
                state_q <= StHold;
                done_q  <= 1'b1;
              end
            end
            default: begin
              // Bounce: turn around on the step after reaching an end, so each
              // end LED is lit for exactly one step.
              if (dir_up_q) begin
                if (led_q[NUM_LED-1]) begin
                  dir_up_q <= 1'b0;
                  led_q    <= led_q >> 1;
                end else begin
                  led_q <= led_q << 1;
                end
              end else begin
                if (led_q[0]) begin
                  dir_up_q <= 1'b1;
                  led_q    <= led_q << 1;
                end else begin
                  led_q <= led_q >> 1;
                end
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign led      = led_q;
  assign cur_mode = cur_mode_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: two instances (4 LEDs / 4-cycle step, and
// 8 LEDs / 2-cycle step starting in ROT_R). A step-index model predicts every
// output each cycle; directed literal checks pin the model to known patterns.
module tb_led_pattern_gen;

  localparam int NA = 4;
  localparam int TA = 4;
  localparam int NB = 8;
  localparam int TB = 2;
  localparam int IB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_ml, a_rs, a_ps;
  logic [1:0] a_mode;
  logic [3:0] a_led;
  logic [1:0] a_cm;
  logic       a_tick, a_done;

  logic       b_rst, b_ml, b_rs, b_ps;
  logic [1:0] b_mode;
  logic [7:0] b_led;
  logic [1:0] b_cm;
  logic       b_tick, b_done;

  int n_tests = 0;
  int n_fail  = 0;

  led_pattern_gen #(
    .NUM_LED   (NA),
    .TICK_CNT  (TA),
    .INIT_MODE (2'd0)
  ) u_dut_a (
    .sys_clk   (clk),
    .sys_rst   (a_rst),
    .mode      (a_mode),
    .mode_load (a_ml),
    .restart   (a_rs),
    .pause     (a_ps),
    .led       (a_led),
    .cur_mode  (a_cm),
    .tick      (a_tick),
    .done      (a_done)
  );

  led_pattern_gen #(
    .NUM_LED   (NB),
    .TICK_CNT  (TB),
    .INIT_MODE (2'(IB))
  ) u_dut_b (
    .sys_clk   (clk),
    .sys_rst   (b_rst),
    .mode      (b_mode),
    .mode_load (b_ml),
    .restart   (b_rs),
    .pause     (b_ps),
    .led       (b_led),
    .cur_mode  (b_cm),
    .tick      (b_tick),
    .done      (b_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state 0 = waiting for first step, 1 = running, 2 = drained/holding.
  // The pattern is a pure function of mode and the number of steps taken.
  bit m_valid [2];
  int m_state [2];
  int m_cnt   [2];
  int m_mode  [2];
  int m_step  [2];

  function automatic logic [7:0] pattern(input int n, input int md, input int st);
    logic [7:0] one;
    int p;
    int pos;
    one = 8'd1;
    case (md)
      0: return one << (st % n);
      1: return one << (n - 1 - (st % n));
      2: return (st >= n) ? 8'd0 : 8'((1 << (n - st)) - 1);
      default: begin
        p   = st % (2 * n - 2);
        pos = (p < n) ? p : (2 * n - 2 - p);
        return one << pos;
      end
    endcase
  endfunction

  task automatic cmp(input int id, input int n, input int t, input logic [7:0] led,
                     input logic [1:0] cm, input logic tk, input logic dn, input logic ps);
    string nm;
    logic [7:0] e_led;
    logic e_tk;
    nm = (id == 0) ? "A" : "B";
    if (!m_valid[id]) return;
    e_led = (m_state[id] == 1) ? pattern(n, m_mode[id], m_step[id]) : 8'd0;
    e_tk  = !ps && (m_state[id] != 2) && (m_cnt[id] == t - 1);
    check({nm, " led"}, 32'(led), 32'(e_led));
    check({nm, " cur_mode"}, 32'(cm), 32'(m_mode[id]));
    check({nm, " done"}, 32'(dn), 32'(m_state[id] == 2));
    check({nm, " tick"}, 32'(tk), 32'(e_tk));
  endtask

  task automatic advance(input int id, input int n, input int t, input int init,
                         input logic rst, input logic ml, input logic rs, input logic ps,
                         input logic [1:0] md);
    if (rst) begin
      m_valid[id] = 1'b1;
      m_state[id] = 0;
      m_cnt[id]   = 0;
      m_mode[id]  = init;
      m_step[id]  = 0;
    end else if (!m_valid[id]) begin
    end else if (ml) begin
      m_mode[id]  = int'(md);
      m_state[id] = 1;
      m_step[id]  = 0;
      m_cnt[id]   = 0;
    end else if (rs) begin
      m_state[id] = 1;
      m_step[id]  = 0;
      m_cnt[id]   = 0;
    end else if (!ps && m_state[id] != 2) begin
      if (m_cnt[id] == t - 1) begin
        m_cnt[id] = 0;
        if (m_state[id] == 0) begin
          m_state[id] = 1;
          m_step[id]  = 0;
        end else begin
          m_step[id]++;
          if (m_mode[id] == 2 && m_step[id] >= n) m_state[id] = 2;
        end
      end else begin
        m_cnt[id]++;
      end
    end
  endtask

  // Inputs change just after posedge, so at negedge they hold the values the
  // next posedge will sample.
  always @(negedge clk) begin
    cmp(0, NA, TA, {4'b0, a_led}, a_cm, a_tick, a_done, a_ps);
    cmp(1, NB, TB, b_led, b_cm, b_tick, b_done, b_ps);
    advance(0, NA, TA, 0, a_rst, a_ml, a_rs, a_ps, a_mode);
    advance(1, NB, TB, IB, b_rst, b_ml, b_rs, b_ps, b_mode);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    @(negedge clk);
    check(name, act, exp);
  endtask

  initial begin
    a_rst = 1'b1; a_ml = 1'b0; a_rs = 1'b0; a_ps = 1'b0; a_mode = 2'd0;
    b_rst = 1'b1; b_ml = 1'b0; b_rs = 1'b0; b_ps = 1'b0; b_mode = 2'd0;
    cyc(3);
    lit("A reset led", 32'(a_led), 32'h0);
    lit("A reset cur_mode", 32'(a_cm), 32'h0);
    lit("A reset done", 32'(a_done), 32'h0);
    a_rst = 1'b0;

    // ROT_L from IDLE: first step 4 cycles after release
    cyc(4);  lit("A rotl first", 32'(a_led), 32'h1);
    cyc(12); lit("A rotl msb", 32'(a_led), 32'h8);
    cyc(4);  lit("A rotl wrap", 32'(a_led), 32'h1);
    cyc(3);  lit("A tick pulse", 32'(a_tick), 32'h1);
    cyc(1);  lit("A rotl after tick", 32'(a_led), 32'h2);
    lit("A tick low", 32'(a_tick), 32'h0);

    // DRAIN
    a_mode = 2'd2; a_ml = 1'b1; cyc(1); a_ml = 1'b0;
    lit("A drain seed", 32'(a_led), 32'hf);
    lit("A drain mode", 32'(a_cm), 32'h2);
    cyc(4);  lit("A drain 1", 32'(a_led), 32'h7);
    cyc(12); lit("A drain empty", 32'(a_led), 32'h0);
    lit("A drain done", 32'(a_done), 32'h1);
    cyc(20); lit("A hold led", 32'(a_led), 32'h0);
    lit("A hold tick", 32'(a_tick), 32'h0);
    a_rs = 1'b1; cyc(1); a_rs = 1'b0;
    lit("A restart led", 32'(a_led), 32'hf);
    lit("A restart done", 32'(a_done), 32'h0);

    // BOUNCE
    a_mode = 2'd3; a_ml = 1'b1; cyc(1); a_ml = 1'b0;
    lit("A bounce seed", 32'(a_led), 32'h1);
    cyc(12); lit("A bounce top", 32'(a_led), 32'h8);
    cyc(4);  lit("A bounce turn", 32'(a_led), 32'h4);
    cyc(8);  lit("A bounce bottom", 32'(a_led), 32'h1);
    cyc(4);  lit("A bounce up again", 32'(a_led), 32'h2);

    // ROT_R with pause mid-period
    a_mode = 2'd1; a_ml = 1'b1; cyc(1); a_ml = 1'b0;
    lit("A rotr seed", 32'(a_led), 32'h8);
    cyc(4); lit("A rotr 1", 32'(a_led), 32'h4);
    cyc(2); a_ps = 1'b1;
    cyc(10); lit("A paused led", 32'(a_led), 32'h4);
    lit("A paused tick", 32'(a_tick), 32'h0);
    a_ps = 1'b0;
    cyc(1); lit("A resume hold", 32'(a_led), 32'h4);
    cyc(1); lit("A resume step", 32'(a_led), 32'h2);

    // mode_load during pause applies and stays paused
    a_ps = 1'b1; a_mode = 2'd0; a_ml = 1'b1; cyc(1); a_ml = 1'b0;
    lit("A load in pause led", 32'(a_led), 32'h1);
    lit("A load in pause mode", 32'(a_cm), 32'h0);
    cyc(6); lit("A still paused", 32'(a_led), 32'h1);
    a_ps = 1'b0;
    cyc(4); lit("A unpaused step", 32'(a_led), 32'h2);

    // mode_load beats restart; reset beats mode_load
    a_mode = 2'd1; a_ml = 1'b1; a_rs = 1'b1; cyc(1); a_ml = 1'b0; a_rs = 1'b0;
    lit("A ml wins mode", 32'(a_cm), 32'h1);
    lit("A ml wins led", 32'(a_led), 32'h8);
    cyc(5);
    a_rst = 1'b1; a_ml = 1'b1; a_mode = 2'd2; cyc(1); a_rst = 1'b0; a_ml = 1'b0;
    lit("A rst wins led", 32'(a_led), 32'h0);
    lit("A rst wins mode", 32'(a_cm), 32'h0);
    lit("A rst wins done", 32'(a_done), 32'h0);
    cyc(10);

    // 8 LEDs, 2-cycle step, ROT_R out of reset
    b_rst = 1'b0;
    cyc(2);  lit("B rotr seed", 32'(b_led), 32'h80);
    lit("B init mode", 32'(b_cm), 32'h1);
    cyc(2);  lit("B rotr 1", 32'(b_led), 32'h40);
    cyc(12); lit("B rotr lsb", 32'(b_led), 32'h01);
    cyc(2);  lit("B rotr wrap", 32'(b_led), 32'h80);
    b_mode = 2'd3; b_ml = 1'b1; cyc(1); b_ml = 1'b0;
    cyc(40);
    b_mode = 2'd2; b_ml = 1'b1; cyc(1); b_ml = 1'b0;
    cyc(20); lit("B drain done", 32'(b_done), 32'h1);
    b_mode = 2'd0; b_ml = 1'b1; cyc(1); b_ml = 1'b0;
    cyc(5);
    b_rst = 1'b1; cyc(1); b_rst = 1'b0;
    lit("B midreset led", 32'(b_led), 32'h0);
    lit("B midreset mode", 32'(b_cm), 32'h1);
    cyc(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised LED pattern engine for the board LED bank. A prescaled step tick drives one of four run-time selectable patterns: rotate left, rotate right, drain (all on, extinguish one per step, then hold) and bounce. It adds restart, pause and mode switching without a board reset. Sits between the top level and the LED pins, replacing fixed single-pattern LED blocks.

Parameters:
NUM_LED, 4, LED count / width of led; must be >= 2
TICK_CNT, 10_000_000, sys_clk cycles per pattern step (0.2 s at 50 MHz); must be >= 2
INIT_MODE, 2'd0, mode selected out of reset

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous reset, active-high
mode  in  2  requested mode: 0 ROT_L, 1 ROT_R, 2 DRAIN, 3 BOUNCE
mode_load  in  1  one-cycle strobe: latch mode and restart the pattern
restart  in  1  one-cycle strobe: restart the current mode from its seed
pause  in  1  level: freeze prescaler and pattern while high
led  out  NUM_LED  LED drive, 1 = on
cur_mode  out  2  mode currently executing
tick  out  1  one-cycle pulse in the cycle whose closing edge advances the pattern
done  out  1  high while DRAIN has finished and is holding all LEDs off

Behaviour:
- Reset (sync, at sys_clk edge with sys_rst=1): prescaler=0, led=0, cur_mode=INIT_MODE, dir=up, done=0, state=IDLE, tick=0.
- Prescaler counts 0..TICK_CNT-1 and wraps to 0. tick=1 (combinational from count) only when count==TICK_CNT-1 and pause=0 and state!=HOLD. Step period is exactly TICK_CNT cycles.
- States: IDLE, RUN, HOLD.
- IDLE, on tick: led<=seed(cur_mode) -> RUN. Seeds: ROT_L = bit0 only; ROT_R = MSB only; DRAIN = all ones; BOUNCE = bit0 only, dir=up.
- RUN, on tick:
  - ROT_L: rotate left; MSB wraps to bit0.
  - ROT_R: rotate right; bit0 wraps to MSB.
  - DRAIN: led<=led>>1, zero fill. If the result is 0: go to HOLD, done<=1.
  - BOUNCE, dir=up: if led[NUM_LED-1], dir<=down and shift right; else shift left.
  - BOUNCE, dir=down: if led[0], dir<=up and shift left; else shift right. The end LED is shown for exactly one step.
- HOLD: led=0, done=1, prescaler held at 0, no tick. Left only via restart, mode_load or sys_rst.
- mode_load: cur_mode<=mode; led<=seed(mode) at the same edge; dir=up; prescaler<=0; done<=0; state<=RUN. The first step follows TICK_CNT cycles later.
- restart: identical to mode_load but keeps cur_mode.
- pause=1: prescaler, led, dir, state and done all frozen; tick=0. Releasing pause resumes the count where it stopped.
- Priority at any edge: sys_rst > mode_load > restart > pause > tick. mode_load/restart during pause still apply, and the block stays paused after the reload.
- Reset mid-pattern: next cycle equals the reset state regardless of inputs.
- All outputs are registered except tick.

Decomposition:
- Shared package (led_pkg): mode encodings (MODE_ROT_L=2'd0, MODE_ROT_R=2'd1, MODE_DRAIN=2'd2, MODE_BOUNCE=2'd3) and state encodings.
- Sub-module led_tick_gen (params TICK_CNT; ports sys_clk, sys_rst, clr, en, tick): prescaler with sync clear and enable. Reused by other timing blocks.
- Pattern FSM stays in the top module.

Test Plan:
- NUM_LED=4, TICK_CNT=4, INIT_MODE=0: release reset -> led=0000 for 4 cycles, then 0001, 0010, 0100, 1000, 0001, one step every 4 cycles; tick pulses every 4th cycle.
- mode=2 with mode_load pulse -> led=1111 next cycle, then 0111, 0011, 0001, 0000 with done=1 on the 0000 edge. Hold 20 cycles: led stays 0000, tick=0. restart pulse -> 1111, done=0.
- mode=3 BOUNCE -> 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010; each end shown exactly once.
- pause high for 10 cycles mid-ROT_R at led=0100 -> led and prescaler frozen, no tick. After release, next step (0010) arrives after the remaining prescaler count, not a full period.
- Same-cycle mode_load (mode=1) and restart in ROT_L -> mode_load wins: cur_mode=1, led=1000. sys_rst asserted in the same cycle as mode_load -> reset state (led=0000, cur_mode=INIT_MODE).
- NUM_LED=8, TICK_CNT=2, ROT_R: 10000000 -> 01000000 ... 00000001 -> 10000000 wrap, steps every 2 cycles.
